// File: rtl/bitstream_refill.sv
// Decoder-side bit window: accepts encoder byte bundles and exposes an
// MSB-aligned window, consuming bits on request and padding with ones at end.
module bitstream_refill #(
   parameter int WINDOW_WIDTH = 64,
   parameter int OUT_WIDTH    = 16,
   parameter int BYTE_WIDTH   = 8,
   parameter int MAX_BYTES    = 5,
   parameter int CNT_WIDTH    = 7,
   parameter int SHIFT_WIDTH  = 5
) (
   input  logic                   rf_clk,
   input  logic                   rf_reset,
   input  logic                   rf_flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_count,
   input  logic [BYTE_WIDTH-1:0]  in_byte_1,
   input  logic [BYTE_WIDTH-1:0]  in_byte_2,
   input  logic [BYTE_WIDTH-1:0]  in_byte_3,
   input  logic [BYTE_WIDTH-1:0]  in_byte_4,
   input  logic [BYTE_WIDTH-1:0]  in_byte_5,
   input  logic                   in_last,
   input  logic                   shift_en,
   input  logic [SHIFT_WIDTH-1:0] shift_amt,
   output logic [OUT_WIDTH-1:0]   out_bits,
   output logic                   out_valid,
   output logic                   out_pad,
   output logic                   out_done,
   output logic                   out_err
);

   localparam int BUNDLE_W = MAX_BYTES * BYTE_WIDTH;
   localparam int LOW_W    = WINDOW_WIDTH - BUNDLE_W;
   localparam logic [CNT_WIDTH-1:0] READY_MAX = CNT_WIDTH'(LOW_W);
   localparam logic [CNT_WIDTH-1:0] OUT_W_C   = CNT_WIDTH'(OUT_WIDTH);

   logic [WINDOW_WIDTH-1:0] w_q, w_d, w_s;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_s;
   logic                    last_q, last_d;
   logic                    err_q, err_d;

   logic                    shift_ok, push;
   logic [CNT_WIDTH-1:0]    amt_c, push_bits;
   logic [2:0]              n_bytes;
   logic [BUNDLE_W-1:0]     bundle, keep;
   logic [WINDOW_WIDTH-1:0] ins_mask, ins_data;

   assign in_ready  = !last_q && (cnt_q <= READY_MAX);
   assign out_valid = last_q || (cnt_q >= OUT_W_C);
   assign out_pad   = last_q && (cnt_q < OUT_W_C);
   assign out_done  = last_q && (cnt_q == '0);
   assign out_err   = err_q;
   assign out_bits  = w_q[WINDOW_WIDTH-1 -: OUT_WIDTH];

   assign push   = in_valid && in_ready;
   assign amt_c  = CNT_WIDTH'(shift_amt);
   assign bundle = {in_byte_1, in_byte_2, in_byte_3, in_byte_4, in_byte_5};

   always_comb begin
      shift_ok = shift_en && out_valid
               && (shift_amt <= SHIFT_WIDTH'(OUT_WIDTH))
               && (last_q || (amt_c <= cnt_q));
      w_s   = w_q;
      cnt_s = cnt_q;
      if (shift_ok) begin
         // vacated low bits refill with ones so padding is implicit
         w_s   = (w_q << shift_amt) | ~({WINDOW_WIDTH{1'b1}} << shift_amt);
         cnt_s = (amt_c >= cnt_q) ? '0 : cnt_q - amt_c;
      end

      n_bytes   = (in_count > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : in_count;
      push_bits = CNT_WIDTH'(n_bytes) * CNT_WIDTH'(BYTE_WIDTH);
      keep      = ~({BUNDLE_W{1'b1}} >> push_bits);
      ins_mask  = {keep, {LOW_W{1'b0}}} >> cnt_s;
      ins_data  = {bundle & keep, {LOW_W{1'b0}}} >> cnt_s;

      w_d    = w_s;
      cnt_d  = cnt_s;
      last_d = last_q;
      err_d  = err_q || (shift_en && !shift_ok);
      if (push) begin
         w_d    = (w_s & ~ins_mask) | ins_data;
         cnt_d  = cnt_s + push_bits;
         last_d = last_q || in_last;
         if (in_count > 3'(MAX_BYTES)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge rf_clk or posedge rf_reset) begin
      if (rf_reset) begin
         w_q    <= '1;
         cnt_q  <= '0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (rf_flush) begin
         w_q    <= '1;
         cnt_q  <= '0;
         last_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         w_q    <= w_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_bitstream_refill.sv
// Directed bench for bitstream_refill: expectations are queued as stimulus
// is driven and popped after the edge that should produce them.
module tb_bitstream_refill;

   logic        rf_clk = 1'b0;
   logic        rf_reset, rf_flush;
   logic        in_valid, in_ready, in_last;
   logic [2:0]  in_count;
   logic [7:0]  b1, b2, b3, b4, b5;
   logic        shift_en;
   logic [4:0]  shift_amt;
   logic [15:0] out_bits;
   logic        out_valid, out_pad, out_done, out_err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] bits;
      logic        valid;
      logic        pad;
      logic        done;
      logic        err;
      logic        ready;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];

   bitstream_refill dut (
      .rf_clk    (rf_clk),
      .rf_reset  (rf_reset),
      .rf_flush  (rf_flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .in_byte_1 (b1),
      .in_byte_2 (b2),
      .in_byte_3 (b3),
      .in_byte_4 (b4),
      .in_byte_5 (b5),
      .in_last   (in_last),
      .shift_en  (shift_en),
      .shift_amt (shift_amt),
      .out_bits  (out_bits),
      .out_valid (out_valid),
      .out_pad   (out_pad),
      .out_done  (out_done),
      .out_err   (out_err)
   );

   always #5 rf_clk = ~rf_clk;

   task automatic idle();
      rf_flush  = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_count  = 3'd0;
      {b1, b2, b3, b4, b5} = '0;
      shift_en  = 1'b0;
      shift_amt = 5'd0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] bits,
                             input logic v, input logic p, input logic d,
                             input logic e, input logic r);
      exp_t x;
      x.bits = bits; x.valid = v; x.pad = p;
      x.done = d; x.err = e; x.ready = r;
      sb_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   task automatic cmp(input string tag, input string f,
                      input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s.%s got=%h exp=%h", tag, f, got, exp);
      end
   endtask

   task automatic check_out();
      exp_t  x;
      string t;
      checks++;
      assert (sb_q.size() != 0) else begin
         failures++;
         $error("FAIL scoreboard empty got=0 exp=1");
      end
      if (sb_q.size() != 0) begin
         x = sb_q.pop_front();
         t = tag_q.pop_front();
         cmp(t, "out_bits", out_bits, x.bits);
         cmp(t, "out_valid", 16'(out_valid), 16'(x.valid));
         cmp(t, "out_pad", 16'(out_pad), 16'(x.pad));
         cmp(t, "out_done", 16'(out_done), 16'(x.done));
         cmp(t, "out_err", 16'(out_err), 16'(x.err));
         cmp(t, "in_ready", 16'(in_ready), 16'(x.ready));
      end
   endtask

   task automatic cycle();
      @(posedge rf_clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rf_reset = 1'b1;
      cycle();
      rf_reset = 1'b0;
   endtask

   task automatic push(input logic [2:0] n, input logic [7:0] x1,
                       input logic [7:0] x2, input logic [7:0] x3,
                       input logic [7:0] x4, input logic [7:0] x5,
                       input logic last);
      in_valid = 1'b1;
      in_count = n;
      {b1, b2, b3, b4, b5} = {x1, x2, x3, x4, x5};
      in_last  = last;
   endtask

   task automatic shift(input logic [4:0] amt);
      shift_en  = 1'b1;
      shift_amt = amt;
   endtask

   initial begin
      rf_reset = 1'b0;
      idle();

      // 1: reset state, then two-byte push
      do_reset();
      expect_out("rst", 16'hFFFF, 0, 0, 0, 0, 1);
      check_out();
      push(3'd2, 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);
      expect_out("t1", 16'hA53C, 1, 0, 0, 0, 1);
      cycle(); idle(); check_out();

      // 2: shift 4 with a same-cycle byte landing behind the data
      shift(5'd4);
      push(3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      expect_out("t2", 16'h53C0, 1, 0, 0, 0, 1);
      cycle(); idle(); check_out();

      // 3: full bundle held valid for three cycles
      do_reset();
      push(3'd5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b0);
      for (int i = 0; i < 3; i++) begin
         expect_out("t3hold", 16'h0102, 1, 0, 0, 0, 0);
         cycle(); check_out();
      end
      idle();
      shift(5'd16);
      expect_out("t3shift", 16'h0304, 1, 0, 0, 0, 1);
      cycle(); idle(); check_out();
      push(3'd5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b0);
      expect_out("t3push2", 16'h0304, 1, 0, 0, 0, 0);
      cycle(); idle(); check_out();
      shift(5'd16);
      expect_out("t3seam", 16'h0501, 1, 0, 0, 0, 0);
      cycle(); idle(); check_out();

      // 4: last bundle, padding and saturation
      do_reset();
      push(3'd1, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      expect_out("t4last", 16'h80FF, 1, 1, 0, 0, 0);
      cycle(); idle(); check_out();
      shift(5'd8);
      expect_out("t4drain", 16'hFFFF, 1, 1, 1, 0, 0);
      cycle(); idle(); check_out();
      shift(5'd16);
      expect_out("t4pad", 16'hFFFF, 1, 1, 1, 0, 0);
      cycle(); idle(); check_out();

      // 5: protocol errors and flush
      do_reset();
      shift(5'd5);
      expect_out("t5ill", 16'hFFFF, 0, 0, 0, 1, 1);
      cycle(); idle(); check_out();
      rf_flush = 1'b1;
      expect_out("t5flush", 16'hFFFF, 0, 0, 0, 0, 1);
      cycle(); idle(); check_out();
      push(3'd7, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b0);
      expect_out("t5cnt7", 16'h1122, 1, 0, 0, 1, 0);
      cycle(); idle(); check_out();
      rf_flush = 1'b1;
      cycle(); idle();
      shift(5'd4);
      push(3'd2, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 1'b0);
      expect_out("t5illpush", 16'hAABB, 1, 0, 0, 1, 1);
      cycle(); idle(); check_out();
      rf_flush = 1'b1;
      shift(5'd4);
      push(3'd1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      expect_out("t5prio", 16'hFFFF, 0, 0, 0, 0, 1);
      cycle(); idle(); check_out();

      // 6: async reset between edges mid-stream
      do_reset();
      push(3'd1, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      cycle();
      push(3'd1, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      expect_out("t6mid", 16'hDEAD, 1, 0, 0, 0, 1);
      cycle(); idle(); check_out();
      #2;
      rf_reset = 1'b1;
      #1;
      expect_out("t6async", 16'hFFFF, 0, 0, 0, 0, 1);
      check_out();
      #1;
      rf_reset = 1'b0;
      push(3'd2, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0);
      expect_out("t6after", 16'h1234, 1, 0, 0, 0, 1);
      cycle(); idle(); check_out();

      checks++;
      assert (sb_q.size() == 0) else begin
         failures++;
         $error("FAIL sb_leftover got=%0d exp=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bitstream_refill.md
Name: bitstream_refill

Overview:
- Decoder-side front end. It consumes the byte bundles produced by the encoder's carry-propagation output: up to 5 bytes per cycle plus a 3-bit count.
- It keeps an MSB-aligned bit window for the arithmetic decoder's renormalisation step.
- It accepts bundles with a valid/ready handshake and exposes the top OUT_WIDTH window bits.
- It consumes 0..OUT_WIDTH bits per cycle on request. Once the stream ends, the window is padded with ones.

Parameters:
- WINDOW_WIDTH, 64, bit-window register width
- OUT_WIDTH, 16, bits exposed to the decoder per cycle
- BYTE_WIDTH, 8, width of each bundle byte
- MAX_BYTES, 5, bytes per input bundle
- CNT_WIDTH, 7, width of the valid-bit counter (holds 0..WINDOW_WIDTH)
- SHIFT_WIDTH, 5, width of the shift request (0..OUT_WIDTH)

Ports:
- rf_clk  in  1  clock
- rf_reset  in  1  asynchronous active-high reset
- rf_flush  in  1  synchronous return to the reset state (frame boundary)
- in_valid  in  1  bundle present
- in_ready  out  1  bundle accepted when in_valid and in_ready are both high
- in_count  in  3  number of valid bytes in the bundle (0..5)
- in_byte_1..in_byte_5  in  BYTE_WIDTH each  bundle bytes; byte_1 is oldest (MSB-first)
- in_last  in  1  this bundle is the final one of the stream
- shift_en  in  1  consume request
- shift_amt  in  SHIFT_WIDTH  bits to consume
- out_bits  out  OUT_WIDTH  window[WINDOW_WIDTH-1 -: OUT_WIDTH]
- out_valid  out  1  out_bits usable
- out_pad  out  1  out_bits contains padding ones
- out_done  out  1  stream ended and all real bits consumed
- out_err  out  1  sticky protocol error

Behaviour:
- State: window W (WINDOW_WIDTH bits), cnt (real bits held, MSB-aligned), last_seen, err. Bits below position cnt are always 1.
- Reset (async) and flush (sync) set W to all ones, cnt=0, last_seen=0, err=0.
- Reset output values: in_ready=1, out_bits=all ones, out_valid=0, out_pad=0, out_done=0, out_err=0.
- in_ready = !last_seen && cnt <= WINDOW_WIDTH - MAX_BYTES*BYTE_WIDTH. It is computed from registered state only; no path from shift_en.
- out_valid = last_seen || cnt >= OUT_WIDTH.
- out_pad = last_seen && cnt < OUT_WIDTH.
- out_done = last_seen && cnt == 0.
- All outputs are driven directly from registers or from register-only logic.
- Per-cycle update order: shift first, then append.
- Shift, legal when shift_en && out_valid && shift_amt <= OUT_WIDTH && (last_seen || shift_amt <= cnt):
  - W' = (W << shift_amt) with the low shift_amt bits set to 1.
  - cnt' = cnt - shift_amt, saturating at 0 (saturation only possible when last_seen).
- Illegal shift: W and cnt are unchanged for the shift, err is set to 1 (sticky until reset/flush). A same-cycle push still proceeds.
- Push (in_valid && in_ready): byte k (1..in_count) is written at W'[WINDOW_WIDTH-1-cnt'-(k-1)*BYTE_WIDTH -: BYTE_WIDTH]. Then cnt'' = cnt' + in_count*BYTE_WIDTH.
  - Bytes with k > in_count are ignored.
  - in_count=0 is a legal no-op push.
  - in_count > 5 is treated as 5 and sets err.
- in_last is sampled only on an accepted push; last_seen is set to 1.
- Latency: a push or shift at edge N is reflected on out_bits, out_valid, in_ready and out_pad after edge N. One cycle, no bypass.
- Shift and push in the same cycle are both honoured; the byte lands behind the shifted data.
- cnt never exceeds WINDOW_WIDTH, guaranteed by the in_ready threshold (24 for the defaults).
- After last_seen, in_ready=0 until flush or reset. Shifts continue to return padding ones indefinitely.
- Async reset asserted mid-stream clears all state immediately. After release, the first edge behaves as after power-up.
- Flush takes priority over a same-cycle push or shift.

Test Plan:
1. Reset, push in_count=2, bytes 0xA5,0x3C -> next cycle out_bits=0xA53C, out_valid=1, cnt=16, in_ready=1, out_pad=0.
2. From case 1: shift_amt=4 with a same-cycle push of in_count=1, byte 0x00 -> out_bits=0x53C0, cnt=20, out_err=0.
3. Reset, push in_count=5 (0x01..0x05) held valid for 3 cycles -> one bundle accepted, cnt=40, in_ready=0. Then shift 16 -> cnt=24, in_ready=1, second bundle accepted next cycle.
4. Reset, push in_count=1, byte 0x80, in_last=1 -> out_bits=0x80FF, out_valid=1, out_pad=1, in_ready=0. Then shift 8 -> out_bits=0xFFFF, out_done=1. Further shift 16 -> out_err stays 0.
5. Reset, shift_en with shift_amt=5 and cnt=0, not last -> out_err=1, out_valid=0, out_bits=0xFFFF. Then flush -> out_err=0.
6. Stream of 3 bundles; assert rf_reset asynchronously between edges after the second bundle -> outputs return to reset values immediately. After release, a new bundle 0x12,0x34 gives out_bits=0x1234.
